// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a valid/ready handshake.
// With SKID=1 a second (skid) entry lets o_ready depend only on registered
// state, so no combinational path runs from i_ready to o_ready.
// With SKID=0 the stage holds a single entry and o_ready follows i_ready.
// Flush empties the stage and clears the control flags; the payload
// registers keep their old values. i_step=0 freezes the stage.
//
// state | meaning
// ------+---------------------------------------------------
// EMPTY | no entry held
// HALF  | main entry valid (head of the stage)
// FULL  | main and skid entries valid (SKID=1 only)
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_step,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   main_data_q;
  logic [CTRL_W-1:0]   main_ctrl_q;
  logic [DATA_W-1:0]   skid_data_q;
  logic [CTRL_W-1:0]   skid_ctrl_q;
  logic [1:0]          occ_q;

  logic main_valid;
  logic ready_raw;
  logic acc;
  logic rel;

  assign main_valid = (state_q != EMPTY);

  // Ready before step/reset gating: registered-only when the skid entry exists.
  always_comb begin
    ready_raw = 1'b0;
    if (SKID != 0) begin
      ready_raw = (state_q != FULL);
    end else begin
      ready_raw = !main_valid || i_ready;
    end
  end

  assign o_ready = i_step & i_rst_n & ready_raw;
  assign o_valid = i_step & main_valid;
  assign acc     = i_valid & o_ready;
  assign rel     = o_valid & i_ready;
  assign o_data  = main_data_q;
  assign o_ctrl  = o_valid ? main_ctrl_q : '0;
  assign o_occ   = occ_q;

  // Stage FSM: accept/release on the same edge, flush overrides both.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      occ_q       <= 2'd0;
    end else if (i_flush) begin
      // Payload is intentionally kept; only the flags are cleared.
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      occ_q       <= 2'd0;
    end else if (i_step) begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_data_q <= i_data;
            main_ctrl_q <= i_ctrl;
            state_q     <= HALF;
            occ_q       <= 2'd1;
          end
        end
        HALF: begin
          if (acc && !rel && (SKID != 0)) begin
            skid_data_q <= i_data;
            skid_ctrl_q <= i_ctrl;
            state_q     <= FULL;
            occ_q       <= 2'd2;
          end else if (rel && !acc) begin
            state_q <= EMPTY;
            occ_q   <= 2'd0;
          end else if (acc && rel) begin
            main_data_q <= i_data;
            main_ctrl_q <= i_ctrl;
          end
        end
        FULL: begin
          if (rel) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            state_q     <= HALF;
            occ_q       <= 2'd1;
          end
        end
        default: begin
          state_q <= EMPTY;
          occ_q   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1 and a SKID=0 instance share the same
// stimulus. Each is compared every cycle against a queue model; a directed
// table additionally carries hand-derived expectations for the SKID=1 stage.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n, step, flush, valid, rdy;
  logic [31:0] din;
  logic [7:0]  cin;

  logic        ready1, valid1, ready0, valid0;
  logic [31:0] data1, data0;
  logic [7:0]  ctrl1, ctrl0;
  logic [1:0]  occ1, occ0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_step(step), .i_flush(flush),
    .i_valid(valid), .o_ready(ready1), .i_data(din), .i_ctrl(cin),
    .o_valid(valid1), .i_ready(rdy), .o_data(data1), .o_ctrl(ctrl1), .o_occ(occ1)
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_step(step), .i_flush(flush),
    .i_valid(valid), .o_ready(ready0), .i_data(din), .i_ctrl(cin),
    .o_valid(valid0), .i_ready(rdy), .o_data(data0), .o_ctrl(ctrl0), .o_occ(occ0)
  );

  typedef struct {
    logic [31:0] d;
    logic [7:0]  c;
  } ent_t;

  typedef struct {
    logic        r, s, f, v, rd;
    logic [31:0] d;
    logic        ev, er;
    logic [1:0]  eocc;
    logic [31:0] edata;
  } vec_t;

  ent_t q1[$];
  ent_t q0[$];
  logic [31:0] lh1, lh0;
  logic mv1, mr1, mv0, mr0;
  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply inputs, then compare both stages against the queue models.
  task automatic drive_check(input logic r, s, f, v, rd,
                             input logic [31:0] d, input logic [7:0] c);
    logic [7:0] mc1, mc0;
    rst_n = r; step = s; flush = f; valid = v; rdy = rd; din = d; cin = c;
    if (!r) begin
      q1.delete(); q0.delete();
      lh1 = '0; lh0 = '0;
    end
    #1;
    mv1 = s && (q1.size() > 0);
    mr1 = s && r && (q1.size() < 2);
    mv0 = s && (q0.size() > 0);
    mr0 = s && r && ((q0.size() == 0) || rd);
    mc1 = '0;
    mc0 = '0;
    if (mv1) mc1 = q1[0].c;
    if (mv0) mc0 = q0[0].c;
    chk("skid1_valid", {31'd0, valid1}, {31'd0, mv1});
    chk("skid1_ready", {31'd0, ready1}, {31'd0, mr1});
    chk("skid1_occ",   {30'd0, occ1},   q1.size());
    chk("skid1_data",  data1, lh1);
    chk("skid1_ctrl",  {24'd0, ctrl1},  {24'd0, mc1});
    chk("skid0_valid", {31'd0, valid0}, {31'd0, mv0});
    chk("skid0_ready", {31'd0, ready0}, {31'd0, mr0});
    chk("skid0_occ",   {30'd0, occ0},   q0.size());
    chk("skid0_data",  data0, lh0);
    chk("skid0_ctrl",  {24'd0, ctrl0},  {24'd0, mc0});
  endtask

  // Clock edge: FIFO semantics of the stage applied to the models.
  task automatic advance();
    ent_t e;
    @(posedge clk);
    e.d = din;
    e.c = cin;
    if (rst_n) begin
      if (flush) begin
        q1.delete(); q0.delete();
      end else begin
        if (mv1 && rdy) void'(q1.pop_front());
        if (valid && mr1) q1.push_back(e);
        if (mv0 && rdy) void'(q0.pop_front());
        if (valid && mr0) q0.push_back(e);
        if (q1.size() > 0) lh1 = q1[0].d;
        if (q0.size() > 0) lh0 = q0[0].d;
      end
    end
    #1;
  endtask

  task automatic add(input logic r, s, f, v, rd, input logic [31:0] d,
                     input logic ev, er, input logic [1:0] eocc, input logic [31:0] edata);
    vec_t t;
    t.r = r; t.s = s; t.f = f; t.v = v; t.rd = rd; t.d = d;
    t.ev = ev; t.er = er; t.eocc = eocc; t.edata = edata;
    tbl.push_back(t);
  endtask

  initial begin
    logic [7:0] ectrl;
    logic [7:0] rc;
    logic       rr;

    // reset with i_valid held high, then release
    add(0,1,0,1,1,32'h11, 0,0,2'd0,32'h0);
    add(0,1,0,1,1,32'h11, 0,0,2'd0,32'h0);
    add(1,1,0,0,1,32'h0,  0,1,2'd0,32'h0);
    // back-to-back stream 1..8
    for (int i = 1; i <= 8; i++)
      add(1,1,0,1,1,i, (i > 1), 1, (i > 1) ? 2'd1 : 2'd0, (i > 1) ? i - 1 : 0);
    add(1,1,0,0,1,32'h0, 1,1,2'd1,32'h8);
    add(1,1,0,0,1,32'h0, 0,1,2'd0,32'h8);
    // backpressure: A,B captured, C held upstream, then drained in order
    add(1,1,0,1,0,32'hA, 0,1,2'd0,32'h8);
    add(1,1,0,1,0,32'hB, 1,1,2'd1,32'hA);
    add(1,1,0,1,0,32'hC, 1,0,2'd2,32'hA);
    add(1,1,0,1,1,32'hC, 1,0,2'd2,32'hA);
    add(1,1,0,1,1,32'hC, 1,1,2'd1,32'hB);
    add(1,1,0,0,1,32'h0, 1,1,2'd1,32'hC);
    add(1,1,0,0,1,32'h0, 0,1,2'd0,32'hC);
    // flush while FULL with D offered; payload register keeps its value
    add(1,1,0,1,0,32'h21, 0,1,2'd0,32'hC);
    add(1,1,0,1,0,32'h22, 1,1,2'd1,32'h21);
    add(1,1,1,1,0,32'hDD, 1,0,2'd2,32'h21);
    add(1,1,0,0,0,32'h0,  0,1,2'd0,32'h21);
    add(1,1,0,0,1,32'h0,  0,1,2'd0,32'h21);
    // step freeze holding 0x55, then a single release
    add(1,1,0,1,0,32'h55, 0,1,2'd0,32'h21);
    for (int i = 0; i < 5; i++)
      add(1,0,0,0,1,32'h0, 0,0,2'd1,32'h55);
    add(1,1,0,0,1,32'h0, 1,1,2'd1,32'h55);
    add(1,1,0,0,1,32'h0, 0,1,2'd0,32'h55);
    // reset while an entry is held
    add(1,1,0,1,0,32'h66, 0,1,2'd0,32'h55);
    add(0,1,0,1,1,32'h77, 0,0,2'd0,32'h0);
    add(1,1,0,0,1,32'h0,  0,1,2'd0,32'h0);

    foreach (tbl[i]) begin
      drive_check(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].rd,
                  tbl[i].d, ~tbl[i].d[7:0]);
      ectrl = tbl[i].ev ? ~tbl[i].edata[7:0] : 8'h00;
      chk("tbl_valid", {31'd0, valid1}, {31'd0, tbl[i].ev});
      chk("tbl_ready", {31'd0, ready1}, {31'd0, tbl[i].er});
      chk("tbl_occ",   {30'd0, occ1},   {30'd0, tbl[i].eocc});
      chk("tbl_data",  data1, tbl[i].edata);
      chk("tbl_ctrl",  {24'd0, ctrl1},  {24'd0, ectrl});
      advance();
    end

    // randomized traffic against the queue models
    for (int n = 0; n < 800; n++) begin
      rr = ($urandom_range(0, 99) != 0);
      rc = 8'($urandom);
      drive_check(rr,
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0),
                  $urandom, rc);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
